// File: rtl/excess3_serial_adder_if.sv
// Digit-pair stream in, sum-digit stream out, for the Excess-3 serial adder.
// The slave modport is the adder; the master modport is whoever feeds it
// and drains it.
interface excess3_serial_adder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_last;
  logic       out_err;
  logic       out_trunc;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_digit, out_last, out_err, out_trunc
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_digit, out_last, out_err, out_trunc
  );
endinterface

// File: rtl/excess3_serial_adder.sv
// Digit-serial Excess-3 adder, least significant digit first.
// Each accepted digit pair produces one registered sum digit. An overflow on
// the last pair appends an Excess-3 "1" digit and costs one input bubble.
// Operations longer than MAX_DIGITS are cut off and flagged with out_trunc.
// Optional feature macro: XS3_ERR_CHECK_EN enables the sticky invalid-code
// flag on out_err. When it is not defined, out_err is constant 0.
module excess3_serial_adder #(
  parameter int MAX_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  excess3_serial_adder_if.slave bus
);

  localparam int CNT_W = (MAX_DIGITS > 2) ? $clog2(MAX_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CARRY = 2'd2
  } state_t;

  // Binary add of two Excess-3 digits plus carry, then the +3/-3 correction.
  // Returns {carry_out, corrected_digit}.
  function automatic logic [4:0] xs3_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (s[4]) return {1'b1, s[3:0] + 4'd3};
    else      return {1'b0, s[3:0] - 4'd3};
  endfunction

  state_t          state_q;
  logic            carry_q;
  logic [CNT_W-1:0] count_q;
  logic            trunc_q;

  logic            vld_p1;
  logic [3:0]      digit_p1;
  logic            last_p1;
  logic            trunc_p1;
  logic            err_p1;

  logic            in_rdy;
  logic            accept;
  logic            carry_issue;
  logic [4:0]      add_res;
  logic [3:0]      sum_digit;
  logic            nxt_carry;
  logic            force_last;
  logic            is_last;
  logic            trunc_now;

  assign in_rdy      = (state_q != CARRY) && (!vld_p1 || bus.out_ready);
  assign accept      = bus.in_valid && in_rdy;
  assign carry_issue = (state_q == CARRY) && (!vld_p1 || bus.out_ready);
  assign add_res     = xs3_digit_add(bus.in_a, bus.in_b, carry_q);
  assign sum_digit   = add_res[3:0];
  assign nxt_carry   = add_res[4];
  assign force_last  = (count_q == LAST_CNT);
  assign is_last     = bus.in_last || force_last;
  assign trunc_now   = force_last && !bus.in_last;

  // Operation FSM plus the registered output stage (stage p1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      carry_q  <= 1'b0;
      count_q  <= '0;
      trunc_q  <= 1'b0;
      vld_p1   <= 1'b0;
      digit_p1 <= 4'd0;
      last_p1  <= 1'b0;
      trunc_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      digit_p1 <= sum_digit;
      last_p1  <= is_last && !nxt_carry;
      trunc_p1 <= trunc_now;
      if (is_last) begin
        count_q <= '0;
        carry_q <= 1'b0;
        if (nxt_carry) begin
          state_q <= CARRY;
          trunc_q <= trunc_now;
        end else begin
          state_q <= IDLE;
          trunc_q <= 1'b0;
        end
      end else begin
        state_q <= RUN;
        count_q <= count_q + CNT_W'(1);
        carry_q <= nxt_carry;
      end
    end else if (carry_issue) begin
      vld_p1   <= 1'b1;
      digit_p1 <= 4'b0100;
      last_p1  <= 1'b1;
      trunc_p1 <= trunc_q;
      trunc_q  <= 1'b0;
      state_q  <= IDLE;
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef XS3_ERR_CHECK_EN
  // Codes outside 0011..1100 are not Excess-3 decimal digits.
  function automatic logic xs3_invalid(input logic [3:0] d);
    return (d <= 4'd2) || (d >= 4'd13);
  endfunction

  logic err_q;
  logic err_now;

  assign err_now = err_q || xs3_invalid(bus.in_a) || xs3_invalid(bus.in_b);

  // Sticky invalid-code flag, carried through to the overflow digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      err_p1 <= 1'b0;
    end else if (accept) begin
      err_p1 <= err_now;
      err_q  <= (is_last && !nxt_carry) ? 1'b0 : err_now;
    end else if (carry_issue) begin
      err_p1 <= err_q;
      err_q  <= 1'b0;
    end
  end
`else
  assign err_p1 = 1'b0;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_digit = digit_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_err   = err_p1;
  assign bus.out_trunc = trunc_p1;

endmodule
